// File: rtl/snow64_icache_fill_responder_pkg.sv
// Shared types and constants for the instruction-cache line-fill path.
package PkgSnow64InstrCache;

  localparam int unsigned WIDTH__SNOW64_CPU_ADDR = 64;
  localparam int unsigned WIDTH__SNOW64_ICACHE_LINE_DATA = 256;
  localparam int unsigned WIDTH__SNOW64_ICACHE_BEAT = 64;
  localparam int unsigned SNOW64_ICACHE_LINE_BEATS =
      WIDTH__SNOW64_ICACHE_LINE_DATA / WIDTH__SNOW64_ICACHE_BEAT;

  // Byte offset bits inside one 32-byte line.
  localparam logic [WIDTH__SNOW64_CPU_ADDR-1:0] SNOW64_ICACHE_LINE_OFFSET_MASK = 64'h1F;

  typedef logic [1:0] beat_idx_t;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBeat,
    StRespond
  } icache_fill_state_t;

  // Line-fill request from the instruction cache.
  typedef struct packed {
    logic                              req;
    logic [WIDTH__SNOW64_CPU_ADDR-1:0] addr;
  } fill_req_t;

  // Line-fill response back to the instruction cache.
  typedef struct packed {
    logic                                      valid;
    logic                                      busy;
    logic [WIDTH__SNOW64_ICACHE_LINE_DATA-1:0] data;
  } fill_resp_t;

  // Beat read request towards backing memory.
  typedef struct packed {
    logic                              req;
    logic [WIDTH__SNOW64_CPU_ADDR-1:0] addr;
  } mem_rd_req_t;

  // Beat read response from backing memory.
  typedef struct packed {
    logic                                 valid;
    logic [WIDTH__SNOW64_ICACHE_BEAT-1:0] data;
  } mem_rd_resp_t;

  // Beat address inside a line; OR instead of add so it can never carry out of the line.
  function automatic logic [WIDTH__SNOW64_CPU_ADDR-1:0] beat_addr(
      input logic [WIDTH__SNOW64_CPU_ADDR-1:0] line_base,
      input beat_idx_t                         idx);
    return line_base | {59'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/snow64_icache_fill_responder.sv
// Fills one 256-bit instruction-cache line from four sequential 64-bit memory beats,
// with at most one beat outstanding, then returns the line as a one-cycle pulse.
module snow64_icache_fill_responder
  import PkgSnow64InstrCache::*;
#(
  parameter int unsigned WIDTH__BEAT = WIDTH__SNOW64_ICACHE_BEAT,  // only 64 is legal
  parameter int unsigned LINE_BEATS  = SNOW64_ICACHE_LINE_BEATS
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_req,
  input  logic [WIDTH__SNOW64_CPU_ADDR-1:0]         in_addr,
  output logic                                      out_valid,
  output logic [WIDTH__SNOW64_ICACHE_LINE_DATA-1:0] out_data,
  output logic                                      out_busy,
  output logic                                      out_mem_rd_req,
  output logic [WIDTH__SNOW64_CPU_ADDR-1:0]         out_mem_rd_addr,
  input  logic                                      in_mem_rd_valid,
  input  logic [WIDTH__BEAT-1:0]                    in_mem_rd_data
);

  localparam beat_idx_t LastBeat = beat_idx_t'(LINE_BEATS - 1);

  icache_fill_state_t                        state_q;
  beat_idx_t                                 k_q;
  logic [WIDTH__SNOW64_CPU_ADDR-1:0]         base_q;
  logic [WIDTH__SNOW64_ICACHE_LINE_DATA-1:0] line_q;
  mem_rd_req_t                               mem_req_q;
  fill_resp_t                                fill_resp_q;

  fill_req_t    fill_req;
  mem_rd_resp_t mem_resp;

  assign fill_req = '{req: in_req, addr: in_addr};
  assign mem_resp = '{valid: in_mem_rd_valid, data: in_mem_rd_data};

  assign out_valid       = fill_resp_q.valid;
  assign out_busy        = fill_resp_q.busy;
  assign out_data        = fill_resp_q.data;
  assign out_mem_rd_req  = mem_req_q.req;
  assign out_mem_rd_addr = mem_req_q.addr;

  // Fill FSM: capture line base, issue beats one at a time, assemble and return the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      k_q         <= '0;
      base_q      <= '0;
      line_q      <= '0;
      mem_req_q   <= '0;
      fill_resp_q <= '0;
    end else begin
      // Request and response strobes are single-cycle pulses.
      mem_req_q.req     <= 1'b0;
      fill_resp_q.valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          // A memory valid here is stale and is dropped, even alongside a new request.
          if (fill_req.req) begin
            base_q            <= fill_req.addr & ~SNOW64_ICACHE_LINE_OFFSET_MASK;
            k_q               <= '0;
            mem_req_q.req     <= 1'b1;
            mem_req_q.addr    <= fill_req.addr & ~SNOW64_ICACHE_LINE_OFFSET_MASK;
            fill_resp_q.busy  <= 1'b1;
            state_q           <= StWaitBeat;
          end
        end

        StWaitBeat: begin
          if (mem_resp.valid) begin
            line_q[k_q*WIDTH__BEAT +: WIDTH__BEAT] <= mem_resp.data;
            if (k_q == LastBeat) begin
              state_q <= StRespond;
            end else begin
              k_q            <= k_q + 2'd1;
              mem_req_q.req  <= 1'b1;
              mem_req_q.addr <= beat_addr(base_q, k_q + 2'd1);
            end
          end
        end

        StRespond: begin
          fill_resp_q.valid <= 1'b1;
          fill_resp_q.data  <= line_q;
          fill_resp_q.busy  <= 1'b0;
          state_q           <= StIdle;
        end

        default: begin
          state_q          <= StIdle;
          fill_resp_q.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_icache_fill_responder.sv
// Randomized self-checking bench for the instruction-cache line-fill responder.
module tb_snow64_icache_fill_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req;
  logic [63:0]  in_addr;
  logic         out_valid;
  logic [255:0] out_data;
  logic         out_busy;
  logic         out_mem_rd_req;
  logic [63:0]  out_mem_rd_addr;
  logic         in_mem_rd_valid;
  logic [63:0]  in_mem_rd_data;

  snow64_icache_fill_responder dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_req          (in_req),
    .in_addr         (in_addr),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_busy        (out_busy),
    .out_mem_rd_req  (out_mem_rd_req),
    .out_mem_rd_addr (out_mem_rd_addr),
    .in_mem_rd_valid (in_mem_rd_valid),
    .in_mem_rd_data  (in_mem_rd_data)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned start_edge = 0;
  int unsigned overlap_cnt = 0;
  int unsigned stale_req = 0;
  logic [63:0] cur_addr = '0;
  bit          pattern_mode = 1'b1;
  bit          rand_lat = 1'b0;
  logic [31:0] mem_salt = '0;

  // Backing memory contents: one 64-bit word per aligned address.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (pattern_mode) return 64'h1111_0000_0000_0000 * (((a >> 3) & 64'h3) + 64'h1);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ {mem_salt, ~mem_salt};
  endfunction

  // A line is the four memory words of its 32-byte block, lowest address least significant.
  function automatic logic [255:0] expect_line(input logic [63:0] a);
    logic [255:0] l;
    logic [63:0]  base;
    base = a & ~64'h1F;
    for (int i = 0; i < 4; i++) l[i*64 +: 64] = mem_word(base + 64'(i * 8));
    return l;
  endfunction

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: answers each beat request after 1 (or 1..21) cycles; also injects stale valids.
  initial begin
    int unsigned stale_seen = 0;
    int unsigned resp_cnt = 0;
    bit          pending = 1'b0;
    logic [63:0] resp_addr = '0;
    in_mem_rd_valid = 1'b0;
    in_mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      in_mem_rd_valid = 1'b0;
      if (!rst_n) begin
        pending  = 1'b0;
        resp_cnt = 0;
      end
      if (stale_req != stale_seen) begin
        stale_seen      = stale_req;
        in_mem_rd_valid = 1'b1;
        in_mem_rd_data  = 64'hDEAD_BEEF_0BAD_F00D;
      end else if (resp_cnt != 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          in_mem_rd_valid = 1'b1;
          in_mem_rd_data  = mem_word(resp_addr);
          pending         = 1'b0;
        end
      end
      if (rst_n && out_mem_rd_req) begin
        if (pending) overlap_cnt++;
        pending   = 1'b1;
        resp_addr = out_mem_rd_addr;
        resp_cnt  = rand_lat ? 1 + $urandom_range(20, 0) : 1;
      end
    end
  end

  task automatic start_fill(input logic [63:0] addr, input bit sync);
    if (sync) @(negedge clk);
    in_req     = 1'b1;
    in_addr    = addr;
    cur_addr   = addr;
    start_edge = edge_cnt;
  endtask

  // Follows one fill to its out_valid pulse; returns on the negedge where out_valid is seen.
  task automatic wait_fill(input string tag, input bit keep_req, input bit hold_chk,
                           input logic [255:0] hold_val, input bit chk_edge);
    int unsigned nreq;
    int unsigned busy_low;
    int unsigned hold_bad;
    int unsigned ov0;
    int unsigned done_edge;
    bit          done;
    logic [63:0] base;
    nreq = 0; busy_low = 0; hold_bad = 0; ov0 = overlap_cnt; done = 1'b0; done_edge = 0;
    base = cur_addr & ~64'h1F;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (keep_req) in_addr = {$urandom, $urandom};
      else in_req = 1'b0;
      if (out_mem_rd_req) begin
        if (nreq < 4)
          check_eq($sformatf("%s_beat%0d_addr", tag, nreq), 256'(out_mem_rd_addr),
                   256'(base + 64'(nreq * 8)));
        nreq++;
      end
      if (out_valid) begin
        done      = 1'b1;
        done_edge = edge_cnt;
      end else begin
        if (!out_busy) busy_low++;
        if (hold_chk && out_data !== hold_val) hold_bad++;
      end
    end
    in_req = 1'b0;
    check_eq({tag, "_done"}, 256'(done), 256'(1));
    check_eq({tag, "_nbeats"}, 256'(nreq), 256'(4));
    check_eq({tag, "_line"}, out_data, expect_line(cur_addr));
    check_eq({tag, "_busy_low"}, 256'(busy_low), 256'(0));
    check_eq({tag, "_overlap"}, 256'(overlap_cnt - ov0), 256'(0));
    if (hold_chk) check_eq({tag, "_hold"}, 256'(hold_bad), 256'(0));
    if (chk_edge) check_eq({tag, "_edges"}, 256'(done_edge - start_edge), 256'(10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] basic_line;
    logic [255:0] prev;
    logic [63:0]  a;
    int unsigned  cnt_a;
    int unsigned  cnt_b;
    int unsigned  cnt_c;

    basic_line = {64'h4444_0000_0000_0000, 64'h3333_0000_0000_0000,
                  64'h2222_0000_0000_0000, 64'h1111_0000_0000_0000};
    rst_n = 1'b0; in_req = 1'b0; in_addr = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_valid", 256'(out_valid), 256'(0));
    check_eq("rst_busy", 256'(out_busy), 256'(0));
    check_eq("rst_rd_req", 256'(out_mem_rd_req), 256'(0));
    check_eq("rst_rd_addr", 256'(out_mem_rd_addr), 256'(0));
    check_eq("rst_data", out_data, 256'(0));
    rst_n = 1'b1;

    // Unaligned request, 1-cycle memory: known line, valid 9 edges after the request edge.
    start_fill(64'h1004, 1'b1);
    wait_fill("basic", 1'b0, 1'b0, '0, 1'b1);
    check_eq("basic_literal", out_data, basic_line);
    @(negedge clk);
    check_eq("basic_pulse_once", 256'(out_valid), 256'(0));
    check_eq("basic_data_hold", out_data, basic_line);

    // Random per-beat latency must not change the assembled line.
    rand_lat = 1'b1;
    repeat (3) begin
      start_fill(64'h1004, 1'b1);
      wait_fill("randlat", 1'b0, 1'b0, '0, 1'b0);
      check_eq("randlat_literal", out_data, basic_line);
    end

    // Random addresses and memory contents.
    pattern_mode = 1'b0;
    repeat (4) begin
      mem_salt = $urandom;
      start_fill({$urandom, $urandom}, 1'b1);
      wait_fill("randaddr", 1'b0, 1'b0, '0, 1'b0);
    end

    // in_req held high through the whole fill: ignored while busy.
    rand_lat = 1'b0;
    start_fill(64'h2000, 1'b1);
    wait_fill("spam", 1'b1, 1'b0, '0, 1'b1);
    cnt_a = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_mem_rd_req || out_valid) cnt_a++;
    end
    check_eq("spam_tail", 256'(cnt_a), 256'(0));

    // Memory valid coinciding with the request in idle is discarded.
    @(posedge clk);
    #1 stale_req++;
    start_fill(64'h3018, 1'b1);
    wait_fill("idle_valid", 1'b0, 1'b0, '0, 1'b1);

    // Last line of the address space: beats FFE0..FFF8 with no wrap.
    start_fill(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    wait_fill("top", 1'b0, 1'b0, '0, 1'b1);

    // Reset while beat 1 is outstanding, then a stale response.
    start_fill(64'h4040, 1'b1);
    cnt_a = 0;
    for (int i = 0; i < 50 && cnt_a < 2; i++) begin
      @(negedge clk);
      in_req = 1'b0;
      if (out_mem_rd_req) cnt_a++;
    end
    check_eq("rst_mid_beat1", 256'(cnt_a), 256'(2));
    rst_n = 1'b0;
    cnt_b = 0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) cnt_b++;
    end
    check_eq("rst_mid_valid", 256'(out_valid), 256'(0));
    check_eq("rst_mid_busy", 256'(out_busy), 256'(0));
    check_eq("rst_mid_rd_req", 256'(out_mem_rd_req), 256'(0));
    check_eq("rst_mid_rd_addr", 256'(out_mem_rd_addr), 256'(0));
    check_eq("rst_mid_data", out_data, 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1 stale_req++;
    cnt_c = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt_b++;
      if (out_mem_rd_req || out_busy || out_data != '0) cnt_c++;
    end
    check_eq("rst_mid_no_valid", 256'(cnt_b), 256'(0));
    check_eq("rst_stale_quiet", 256'(cnt_c), 256'(0));
    start_fill(64'h5008, 1'b1);
    wait_fill("after_rst", 1'b0, 1'b0, '0, 1'b1);

    // Back-to-back fills: each new request is sampled on the edge right after out_valid.
    mem_salt = $urandom;
    a = {$urandom, $urandom};
    start_fill(a, 1'b1);
    wait_fill("b2b_first", 1'b0, 1'b0, '0, 1'b1);
    prev = expect_line(a);
    repeat (3) begin
      a = {$urandom, $urandom};
      start_fill(a, 1'b0);
      wait_fill("b2b_next", 1'b0, 1'b1, prev, 1'b1);
      prev = expect_line(a);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/snow64_icache_fill_responder.md
SNOW64_ICACHE_FILL_RESPONDER -- requirements
Module: snow64_icache_fill_responder

Interface
REQ-001 SHALL have parameter WIDTH__BEAT, default 64, meaning the backing-memory read data width in bits; the only legal value is 64.
REQ-002 SHALL have parameter LINE_BEATS, default 4, meaning beats per line (256 / WIDTH__BEAT).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-005 SHALL have port in_req, input, 1 bit: instruction-cache line-fill request pulse.
REQ-006 SHALL have port in_addr, input, 64 bits: CPU byte address of the request; any alignment.
REQ-007 SHALL have port out_valid, output, 1 bit: one-cycle pulse that returns a completed line.
REQ-008 SHALL have port out_data, output, 256 bits: the filled instruction-cache line.
REQ-009 SHALL have port out_busy, output, 1 bit: a fill is in progress.
REQ-010 SHALL have port out_mem_rd_req, output, 1 bit: one-cycle backing-memory beat read request.
REQ-011 SHALL have port out_mem_rd_addr, output, 64 bits: beat byte address, 8-byte aligned.
REQ-012 SHALL have port in_mem_rd_valid, input, 1 bit: backing-memory beat data valid.
REQ-013 SHALL have port in_mem_rd_data, input, 64 bits: beat data.

Function
REQ-014 SHALL implement states StIdle, StWaitBeat and StRespond, with all outputs registered.
REQ-015 In StIdle, in_req=1 SHALL capture line base = {in_addr[63:5], 5'b0}, clear beat counter k, assert out_mem_rd_req=1 with out_mem_rd_addr=base, and go to StWaitBeat.
REQ-016 out_mem_rd_req SHALL be high for exactly one cycle per beat, and there SHALL be at most one outstanding beat.
REQ-017 In StWaitBeat, in_mem_rd_valid=1 SHALL write in_mem_rd_data into line buffer bits [k*64 +: 64] (beat 0 least significant).
REQ-018 On that same edge with k<3, the block SHALL increment k and issue the next beat at base+8*(k+1).
REQ-019 On that same edge with k=3, the block SHALL go to StRespond.
REQ-020 StRespond SHALL drive out_valid=1 for one cycle with out_data equal to the assembled line, then return to StIdle.
REQ-021 out_data SHALL hold its last value between pulses.
REQ-022 out_busy SHALL be 1 in StWaitBeat and StRespond and 0 in StIdle.
REQ-023 in_req while out_busy=1 SHALL be ignored, with no queuing; a requester SHALL wait for out_valid.
REQ-024 in_mem_rd_valid outside StWaitBeat SHALL be ignored, including stale responses after reset.
REQ-025 Memory latency SHALL be unbounded, with no timeout.
REQ-026 With memory answering exactly one cycle after each out_mem_rd_req, out_valid SHALL rise 9 edges after the edge sampling in_req.
REQ-027 The beat address SHALL never cross the 32-byte line; base+24 is the maximum.
REQ-028 The address at 0xFFFF_FFFF_FFFF_FFE0 SHALL not wrap.
REQ-029 in_req and in_mem_rd_valid in the same cycle in StIdle SHALL start a new fill and discard the valid.

Reset
REQ-030 On an edge with rst_n=0, the block SHALL set state StIdle and k=0.
REQ-031 On an edge with rst_n=0, out_valid, out_busy, out_mem_rd_req, out_mem_rd_addr, out_data and the line buffer SHALL all be 0.
REQ-032 Reset mid-fill SHALL abandon the fill without asserting out_valid.
REQ-033 Reset SHALL take priority over all other inputs.

Structure
REQ-034 The state enum, WIDTH__SNOW64_ICACHE_LINE_DATA (256) and the beat width constant SHALL live in the shared package PkgSnow64InstrCache.
REQ-035 The package SHALL hold packed structs grouping the request/response ports, matching the instruction cache's memory-access port structs.
REQ-036 The block SHALL be a single module with no sub-module; the line buffer and counter are local.

Verification
REQ-037 Bench SHALL drive in_req with in_addr=0x1004 and memory returning beat k = 0x1111_0000_0000_0000*(k+1), 1-cycle latency -> beat addresses 0x1000/08/10/18, out_valid at edge 9, out_data = {beat3,beat2,beat1,beat0}.
REQ-038 Bench SHALL apply random 0-20 cycle memory latency per beat -> identical line, exactly one out_valid pulse, out_busy high throughout.
REQ-039 Bench SHALL assert in_req again at each cycle of a fill (addr 0x2000) -> no new out_mem_rd_req beyond 4 beats, and the line is for the first address only.
REQ-040 Bench SHALL assert rst_n=0 after beat 1, then inject a stale in_mem_rd_valid -> no out_valid, all outputs 0, and the next fill is correct.
REQ-041 Bench SHALL request address 0xFFFF_FFFF_FFFF_FFFC -> beat addresses …FFE0 through …FFF8, with no wrap.
REQ-042 Bench SHALL run back-to-back fills, with in_req the cycle after out_valid -> the second fill starts immediately and out_data holds the first line until the second out_valid.
